// File: rtl/d_latch.sv
// Transparent WIDTH-bit D latch with async active-low clear, plus an i_clk-domain monitor.
// The monitor gives a registered output, open/close event pulses, and saturating hold and update counters.
module d_latch #(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_reg,
    output logic             o_open,
    output logic             o_close,
    output logic [CNT_W-1:0] o_hold_cnt,
    output logic [CNT_W-1:0] o_upd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0]       latch_q;
    logic [WIDTH-1:0]       q_reg_q;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   en_s;
    logic                   en_d_q;
    logic                   open_q, open_d;
    logic                   close_q, close_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]       upd_q, upd_d;

    // Intentional level-sensitive storage; reset dominates the gate.
    always_latch begin
        if (!i_rst_n) begin
            latch_q <= '0;
        end else if (i_enable) begin
            latch_q <= i_d;
        end
    end

    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_enable};
    assign en_s   = sync_q[SYNC_STAGES-1];

    always_comb begin
        open_d  = en_s & ~en_d_q;
        close_d = ~en_s & en_d_q;

        hold_d = hold_q;
        if (en_s) begin
            hold_d = '0;
        end else if (hold_q != CNT_MAX) begin
            hold_d = hold_q + 1'b1;
        end

        // Compares the value about to be registered against the current register.
        upd_d = upd_q;
        if ((latch_q != q_reg_q) && (upd_q != CNT_MAX)) begin
            upd_d = upd_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_reg_q <= '0;
            sync_q  <= '0;
            en_d_q  <= 1'b0;
            open_q  <= 1'b0;
            close_q <= 1'b0;
            hold_q  <= '0;
            upd_q   <= '0;
        end else begin
            q_reg_q <= latch_q;
            sync_q  <= sync_d;
            en_d_q  <= en_s;
            open_q  <= open_d;
            close_q <= close_d;
            hold_q  <= hold_d;
            upd_q   <= upd_d;
        end
    end

    assign o_q        = latch_q;
    assign o_q_reg    = q_reg_q;
    assign o_open     = open_q;
    assign o_close    = close_q;
    assign o_hold_cnt = hold_q;
    assign o_upd_cnt  = upd_q;

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: a vector table for the async latch core, hand sequences for the clocked monitor.
module tb_d_latch;

    localparam int WIDTH = 1;
    localparam int CNT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_enable;
    logic [WIDTH-1:0] i_d;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_q_reg;
    logic             o_open;
    logic             o_close;
    logic [CNT_W-1:0] o_hold_cnt;
    logic [CNT_W-1:0] o_upd_cnt;

    int checks = 0;
    int errors = 0;

    d_latch #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_d        (i_d),
        .o_q        (o_q),
        .o_q_reg    (o_q_reg),
        .o_open     (o_open),
        .o_close    (o_close),
        .o_hold_cnt (o_hold_cnt),
        .o_upd_cnt  (o_upd_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic rst_n;
        logic en;
        logic d;
        logic exp_q;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // Each row changes one input relative to the previous row.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1};

        i_rst_n  = 1'b0;
        i_enable = 1'b1;
        i_d      = 1'b1;
        #3;

        for (int i = 0; i < 14; i++) begin
            i_rst_n  = vecs[i].rst_n;
            i_enable = vecs[i].en;
            i_d      = vecs[i].d;
            #3;
            check($sformatf("latch_vec%0d", i), int'(o_q), int'(vecs[i].exp_q));
        end

        // Reset with gate closed, then release and watch the hold counter.
        @(negedge i_clk);
        i_rst_n  = 1'b0;
        i_enable = 1'b0;
        #1;
        check("rst_q", int'(o_q), 0);
        check("rst_q_reg", int'(o_q_reg), 0);
        check("rst_hold", int'(o_hold_cnt), 0);
        check("rst_upd", int'(o_upd_cnt), 0);
        check("rst_open", int'(o_open), 0);
        check("rst_close", int'(o_close), 0);

        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("release_q", int'(o_q), 0);
        repeat (10) @(negedge i_clk);
        check("hold_10", int'(o_hold_cnt), 10);
        check("hold_q_zero", int'(o_q), 0);
        check("hold_upd_zero", int'(o_upd_cnt), 0);
        repeat (10) @(negedge i_clk);
        check("hold_sat", int'(o_hold_cnt), 15);

        // Open event: two sync stages plus the pulse register.
        i_d = 1'b0;
        @(negedge i_clk);
        i_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check($sformatf("open_c%0d", i), int'(o_open), (i == 2) ? 1 : 0);
            check($sformatf("open_close_c%0d", i), int'(o_close), 0);
            if (i == 2) check("hold_clear", int'(o_hold_cnt), 0);
        end

        for (int k = 0; k < 6; k++) begin
            i_d = ~i_d;
            #1;
            check($sformatf("transp_%0d", k), int'(o_q), int'(i_d));
            @(negedge i_clk);
            check($sformatf("q_reg_%0d", k), int'(o_q_reg), int'(i_d));
            @(negedge i_clk);
        end
        check("upd_6", int'(o_upd_cnt), 6);

        // Close event and hold behaviour.
        i_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check($sformatf("close_c%0d", i), int'(o_close), (i == 2) ? 1 : 0);
            check($sformatf("close_open_c%0d", i), int'(o_open), 0);
        end
        check("hold_after_close", int'(o_hold_cnt), 4);
        repeat (6) @(negedge i_clk);
        check("hold_10b", int'(o_hold_cnt), 10);

        for (int k = 0; k < 4; k++) begin
            i_d = ~i_d;
            #1;
            check($sformatf("held_q_%0d", k), int'(o_q), 0);
            @(negedge i_clk);
            @(negedge i_clk);
        end
        check("upd_frozen", int'(o_upd_cnt), 6);
        check("held_q_reg", int'(o_q_reg), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_latch.md
Name: d_latch

Overview:
- Level-sensitive transparent D latch, WIDTH bits wide, with an asynchronous active-low clear.
- A clock-domain monitor sits beside the latch. It gives downstream synchronous logic a registered copy of the latch output, synchronized open/close event pulses, and hold-duration and update statistics.
- Used wherever a transparent storage element is needed, e.g. a data hold path gated by a slow enable.

Parameters:
- WIDTH, 1, data width of i_d / o_q.
- CNT_W, 16, width of the hold-cycle and update counters (both saturate).
- SYNC_STAGES, 2, flip-flop stages used to synchronize i_enable into the i_clk domain (minimum 2).

Ports:
- i_clk  input  1  monitor clock; rising edge active.
- i_rst_n  input  1  asynchronous active-low reset; clears latch and all monitor state.
- i_enable  input  1  latch gate, asynchronous to i_clk; 1 = transparent, 0 = hold.
- i_d  input  WIDTH  latch data input.
- o_q  output  WIDTH  latch output.
- o_q_reg  output  WIDTH  o_q sampled on i_clk.
- o_open  output  1  one-cycle pulse when the synchronized enable rises.
- o_close  output  1  one-cycle pulse when the synchronized enable falls.
- o_hold_cnt  output  CNT_W  consecutive i_clk cycles the synchronized enable has been 0.
- o_upd_cnt  output  CNT_W  count of i_clk cycles in which o_q_reg changed value.

Behaviour:
- Reset (i_rst_n=0) is asynchronous and dominant over i_enable.
  - During reset, o_q, o_q_reg, o_open, o_close, o_hold_cnt, o_upd_cnt and the sync chain are all 0.
- Latch core:
  - i_rst_n=1, i_enable=1: o_q follows i_d combinationally (transparent), with no clock involvement.
  - Falling edge of i_enable: o_q keeps the value i_d had at that edge.
  - i_enable=0: o_q holds and ignores all i_d changes.
  - Reset release while i_enable=1: o_q takes i_d immediately.
  - Reset release while i_enable=0: o_q stays 0 until the next transparent phase.
- Every i_clk rising edge:
  - o_q_reg <= o_q (1-cycle latency).
  - Sync chain shifts i_enable in; en_s is the last stage, en_d is the previous en_s.
- Event pulses:
  - o_open = en_s & ~en_d, registered.
  - o_close = ~en_s & en_d, registered.
  - Each pulse lasts exactly 1 cycle per edge.
  - Enable pulses narrower than one i_clk period may be missed. This is permitted.
- o_hold_cnt:
  - Increments each cycle while en_s=0.
  - Resets to 0 in any cycle en_s=1.
  - Saturates at 2^CNT_W-1; no wrap.
- o_upd_cnt:
  - Increments in a cycle when the new o_q_reg differs from the old o_q_reg.
  - Saturates at 2^CNT_W-1; cleared only by reset.
- Simultaneous events: open and close cannot both assert in one cycle. A counter at saturation holds its value.
- Synthesis: the latch core is an intentional latch (no clock). All other state is flip-flops on i_clk with async clear.

Test Plan:
- Reset then hold:
  - Stimulus: i_rst_n=0 with i_enable=1 and i_d=1; release reset with i_enable=0.
  - Response: o_q=0 throughout reset and stays 0 after release; all counters 0.
- Transparency (WIDTH=1):
  - Stimulus: i_enable toggles every 100 ns, i_d toggles every 15 ns, starting at 0.
  - Response during enable-high windows: o_q tracks i_d within a delta cycle.
  - Response at the fall at 200 ns: o_q holds the i_d value at that edge (i_d=1 at t=200) until 300 ns, ignoring toggles at 210, 225, ...
- Mid-transparency reset:
  - Stimulus: assert i_rst_n=0 while i_enable=1, i_d=1.
  - Response: o_q goes to 0 immediately.
  - Stimulus: release reset.
  - Response: o_q=1 again.
- Event pulses:
  - Stimulus: i_clk at 10 ns; i_enable rises at 100 ns.
  - Response: o_open high for exactly one cycle, 2–3 clocks later. o_close behaves the same way after the fall.
- Hold counter:
  - Stimulus: enable low for 100 ns at a 10 ns clock.
  - Response: o_hold_cnt reaches ~10 and clears the cycle after en_s=1.
  - Stimulus: CNT_W=4 with a long hold.
  - Response: saturates at 15.
- Update counter:
  - Stimulus: i_d toggles 6 times, each ≥2 clocks apart, while transparent.
  - Response: o_upd_cnt=6.
  - Stimulus: i_d toggles while holding.
  - Response: o_upd_cnt does not change.
